axil_cmd_master: RTL

//  Single-outstanding AXI4-Lite master that sits directly upstream of axil_ram.

---
 rtl/axil_cmd_master.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI-Lite transaction, one response out.
// Latency >= 3 clocks accept-to-response; cmd_ready_o only in IDLE, response held until rsp_ready_i.
module axil_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_we_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [1:0]            rsp_resp_o,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WB   = 3'd2,
    S_RA   = 3'd3,
    S_RD   = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_resp;

  logic w_cmd_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_wr_both;

  // Every valid/ready is a pure decode of registered state, so no
  // combinational path exists from any slave ready back to a master valid.
  assign cmd_ready_o    = (r_state == S_IDLE);
  assign m_axil_awvalid = (r_state == S_WR) && !r_aw_done;
  assign m_axil_wvalid  = (r_state == S_WR) && !r_w_done;
  assign m_axil_bready  = (r_state == S_WB);
  assign m_axil_arvalid = (r_state == S_RA);
  assign m_axil_rready  = (r_state == S_RD);
  assign rsp_valid_o    = (r_state == S_RSP);

  assign m_axil_awaddr  = r_addr;
  assign m_axil_araddr  = r_addr;
  assign m_axil_wdata   = r_wdata;
  assign m_axil_wstrb   = r_wstrb;
  assign rsp_we_o       = r_we;
  assign rsp_rdata_o    = r_rdata;
  assign rsp_resp_o     = r_resp;

  assign w_cmd_hs  = cmd_valid_i && cmd_ready_o;
  assign w_aw_hs   = m_axil_awvalid && m_axil_awready;
  assign w_w_hs    = m_axil_wvalid && m_axil_wready;
  assign w_b_hs    = m_axil_bvalid && m_axil_bready;
  assign w_ar_hs   = m_axil_arvalid && m_axil_arready;
  assign w_r_hs    = m_axil_rvalid && m_axil_rready;
  assign w_wr_both = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_cmd_hs) w_next = cmd_we_i ? S_WR : S_RA;
      S_WR:   if (w_wr_both) w_next = S_WB;
      S_WB:   if (w_b_hs) w_next = S_RSP;
      S_RA:   if (w_ar_hs) w_next = S_RD;
      S_RD:   if (w_r_hs) w_next = S_RSP;
      S_RSP:  if (rsp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // AW and W may complete in either order; each done flag retires its valid.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_resp    <= 2'b00;
    end else begin
      if (w_cmd_hs) begin
        r_we      <= cmd_we_i;
        r_addr    <= cmd_addr_i;
        r_wdata   <= cmd_wdata_i;
        r_wstrb   <= cmd_wstrb_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_b_hs) begin
        r_rdata <= '0;
        r_resp  <= m_axil_bresp;
      end
      if (w_r_hs) begin
        r_rdata <= m_axil_rdata;
        r_resp  <= m_axil_rresp;
      end
    end
  end

endmodule
